// File: rtl/sfu_out_sched.sv
// -----------------------------------------------------------------------------
// sfu_out_sched
//   Output scheduler sitting in front of the SFU output buffer. Each of the two
//   SFU result lanes is buffered in its own small FIFO. A round-robin arbiter
//   with a per-lane burst limit picks which FIFO feeds a single registered
//   output beat. The output beat is handed over with a valid/ready handshake,
//   which decouples producer bursts from output-buffer backpressure.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rstn       asynchronous reset, active-high (flushes FIFOs and output beat)
//   enable     1 = grants allowed, 0 = arbitration frozen (held beat may drain)
//   in0_data   lane 0 beat, element k at [k*DATA_W +: DATA_W]
//   in0_valid  lane 0 beat present
//   in0_ready  lane 0 FIFO not full
//   in1_data   lane 1 beat
//   in1_valid  lane 1 beat present
//   in1_ready  lane 1 FIFO not full
//   out_data   granted beat (registered)
//   out_src    source lane of out_data
//   out_valid  out_data / out_src valid
//   out_ready  output buffer accepts the beat
//   busy       any FIFO non-empty or an output beat is held
// -----------------------------------------------------------------------------
module sfu_out_sched #(
   parameter int DATA_W     = 32,
   parameter int LANES      = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_BURST  = 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    enable,
   input  logic [LANES*DATA_W-1:0] in0_data,
   input  logic                    in0_valid,
   output logic                    in0_ready,
   input  logic [LANES*DATA_W-1:0] in1_data,
   input  logic                    in1_valid,
   output logic                    in1_ready,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic                    out_src,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    busy
);

   localparam int BW  = LANES * DATA_W;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int BCW = $clog2(MAX_BURST + 1);

   localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0]  CNT_ONE = CW'(1);
   localparam logic [BCW-1:0] MAXB_C  = BCW'(MAX_BURST);
   localparam logic [BCW-1:0] BC_ONE  = BCW'(1);

   // FIFO storage (data only, never reset) and per-lane control state
   logic [BW-1:0] r_mem [2][FIFO_DEPTH];
   logic [AW-1:0] r_wp  [2];
   logic [AW-1:0] r_rp  [2];
   logic [CW-1:0] r_cnt [2];

   // Arbiter state
   logic           r_ptr;
   logic [BCW-1:0] r_bc;

   // Output register
   logic [BW-1:0] r_out_data;
   logic          r_out_src;
   logic          r_out_valid;

   logic [BW-1:0]  w_in_data [2];
   logic [1:0]     w_in_valid;
   logic [1:0]     w_in_ready;
   logic [1:0]     w_ne;
   logic [1:0]     w_push;
   logic [1:0]     w_pop;
   logic           w_load;
   logic           w_grant;
   logic [BCW-1:0] w_bc_next;
   logic [BW-1:0]  w_head;

   assign w_in_data[0] = in0_data;
   assign w_in_data[1] = in1_data;
   assign w_in_valid   = {in1_valid, in0_valid};

   always_comb begin
      for (int l = 0; l < 2; l++) begin
         w_in_ready[l] = (r_cnt[l] != DEPTH_C);
         w_ne[l]       = (r_cnt[l] != '0);
      end
   end

   assign w_push = w_in_valid & w_in_ready;

   // A new beat may enter the output register only when the slot is free or
   // its current beat is being taken this cycle.
   assign w_load = enable & (|w_ne) & (~r_out_valid | out_ready);

   // Burst limit only matters under contention; a lone requester always wins.
   always_comb begin
      w_grant = 1'b0;
      if (w_ne[0] && w_ne[1]) begin
         w_grant = (r_bc >= MAXB_C) ? ~r_ptr : r_ptr;
      end else begin
         w_grant = w_ne[1];
      end
   end

   always_comb begin
      w_bc_next = r_bc;
      if (w_grant != r_ptr) begin
         w_bc_next = BC_ONE;
      end else if (r_bc < MAXB_C) begin
         w_bc_next = r_bc + BC_ONE;
      end
   end

   assign w_pop[0] = w_load & ~w_grant;
   assign w_pop[1] = w_load &  w_grant;
   assign w_head   = w_grant ? r_mem[1][r_rp[1]] : r_mem[0][r_rp[0]];

   // FIFO write port
   always_ff @(posedge clk) begin
      for (int l = 0; l < 2; l++) begin
         if (w_push[l]) begin
            r_mem[l][r_wp[l]] <= w_in_data[l];
         end
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         for (int l = 0; l < 2; l++) begin
            r_wp[l]  <= '0;
            r_rp[l]  <= '0;
            r_cnt[l] <= '0;
         end
      end else begin
         for (int l = 0; l < 2; l++) begin
            if (w_push[l]) begin
               r_wp[l] <= r_wp[l] + 1'b1;
            end
            if (w_pop[l]) begin
               r_rp[l] <= r_rp[l] + 1'b1;
            end
            case ({w_push[l], w_pop[l]})
               2'b10:   r_cnt[l] <= r_cnt[l] + CNT_ONE;
               2'b01:   r_cnt[l] <= r_cnt[l] - CNT_ONE;
               default: r_cnt[l] <= r_cnt[l];
            endcase
         end
      end
   end

   // Arbiter pointer / burst count and output register
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         r_ptr       <= 1'b0;
         r_bc        <= '0;
         r_out_valid <= 1'b0;
         r_out_src   <= 1'b0;
         r_out_data  <= '0;
      end else begin
         if (w_load) begin
            r_ptr       <= w_grant;
            r_bc        <= w_bc_next;
            r_out_valid <= 1'b1;
            r_out_src   <= w_grant;
            r_out_data  <= w_head;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign in0_ready = w_in_ready[0];
   assign in1_ready = w_in_ready[1];
   assign out_data  = r_out_data;
   assign out_src   = r_out_src;
   assign out_valid = r_out_valid;
   assign busy      = (|w_ne) | r_out_valid;

endmodule

// File: tb/tb_sfu_out_sched.sv
// -----------------------------------------------------------------------------
// tb_sfu_out_sched
//   Self-checking bench for sfu_out_sched. A queue-based reference model of the
//   scheduler is advanced on every rising edge; DUT outputs are compared with it
//   on the falling edge. Directed scenarios cover latency, burst sharing,
//   backpressure, enable freeze, asynchronous reset and lone-lane streaming,
//   followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_sfu_out_sched;

   localparam int DATA_W = 32;
   localparam int LANES  = 8;
   localparam int DEPTH  = 4;
   localparam int MAXB   = 4;
   localparam int BW     = LANES * DATA_W;

   logic          clk = 1'b0;
   logic          rstn;
   logic          enable;
   logic [BW-1:0] in0_data, in1_data;
   logic          in0_valid, in1_valid;
   logic          in0_ready, in1_ready;
   logic [BW-1:0] out_data;
   logic          out_src, out_valid, out_ready, busy;

   sfu_out_sched #(
      .DATA_W(DATA_W), .LANES(LANES), .FIFO_DEPTH(DEPTH), .MAX_BURST(MAXB)
   ) dut (
      .clk(clk), .rstn(rstn), .enable(enable),
      .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
      .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
      .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [BW-1:0] q0[$], q1[$];
   logic          m_vld, m_src;
   logic [BW-1:0] m_data;
   int            m_ptr, m_bc;

   function automatic void model_reset();
      q0.delete(); q1.delete();
      m_vld = 1'b0; m_src = 1'b0; m_data = '0; m_ptr = 0; m_bc = 0;
   endfunction

   function automatic void model_edge();
      bit a0, a1, ld;
      int g;
      a0 = in0_valid && (q0.size() < DEPTH);
      a1 = in1_valid && (q1.size() < DEPTH);
      ld = enable && (q0.size() > 0 || q1.size() > 0) && (!m_vld || out_ready);
      if (ld) begin
         if (q0.size() > 0 && q1.size() > 0) g = (m_bc >= MAXB) ? 1 - m_ptr : m_ptr;
         else                                g = (q0.size() > 0) ? 0 : 1;
         m_data = (g == 1) ? q1.pop_front() : q0.pop_front();
         m_src  = g[0];
         m_vld  = 1'b1;
         if (g != m_ptr)     m_bc = 1;
         else if (m_bc < MAXB) m_bc = m_bc + 1;
         m_ptr = g;
      end else if (out_ready) begin
         m_vld = 1'b0;
      end
      if (a0) q0.push_back(in0_data);
      if (a1) q1.push_back(in1_data);
   endfunction

   task automatic check_outs();
      chk("out_valid", out_valid, m_vld);
      chk("out_src",   out_src,   m_src);
      chk("out_data",  out_data,  m_data);
      chk("in0_ready", in0_ready, q0.size() < DEPTH);
      chk("in1_ready", in1_ready, q1.size() < DEPTH);
      chk("busy",      busy,      (q0.size() > 0) || (q1.size() > 0) || m_vld);
   endtask

   // ---------------- stimulus helpers ----------------
   int tid, sent0, sent1, lim0, lim1;
   bit last_acc0, last_acc1;

   function automatic logic [BW-1:0] beat(input int t, input int l, input int i);
      logic [BW-1:0] b;
      for (int k = 0; k < LANES; k++) b[k*DATA_W +: DATA_W] = {8'(t), 8'(l), 8'(i), 8'(k)};
      return b;
   endfunction

   task automatic cyc();
      last_acc0 = in0_valid & in0_ready;
      last_acc1 = in1_valid & in1_ready;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outs();
   endtask

   task automatic drive_next();
      if (last_acc0) sent0++;
      if (last_acc1) sent1++;
      in0_valid = (sent0 < lim0);
      in1_valid = (sent1 < lim1);
      in0_data  = beat(tid, 0, sent0);
      in1_data  = beat(tid, 1, sent1);
   endtask

   task automatic start_test(input int t, input int l0, input int l1);
      tid = t; lim0 = l0; lim1 = l1; sent0 = 0; sent1 = 0;
      last_acc0 = 1'b0; last_acc1 = 1'b0;
      drive_next();
   endtask

   task automatic run(input int n);
      repeat (n) begin
         cyc();
         drive_next();
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      in0_valid = 1'b0; in1_valid = 1'b0;
      rstn = 1'b1;
      @(negedge clk);
      rstn = 1'b0;
      model_reset();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [BW-1:0] exp1;
      logic [15:0]   src_seq;
      int            nb, gaps, started, lone, seen_l1, l0_after;

      rstn = 1'b1; enable = 1'b1; out_ready = 1'b1;
      in0_valid = 1'b0; in1_valid = 1'b0; in0_data = '0; in1_data = '0;
      model_reset();
      @(negedge clk); @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data",  out_data,  '0);
      chk("rst_busy",      busy,      1'b0);
      chk("rst_in0_ready", in0_ready, 1'b1);
      chk("rst_in1_ready", in1_ready, 1'b1);
      rstn = 1'b0;

      // 1: single beat latency
      for (int k = 0; k < LANES; k++) exp1[k*DATA_W +: DATA_W] = 32'(16 + k);
      in0_data = exp1; in0_valid = 1'b1;
      cyc();                       // edge N: accepted
      in0_valid = 1'b0;
      chk("t1_not_yet", out_valid, 1'b0);
      cyc();                       // edge N+1
      chk("t1_valid", out_valid, 1'b1);
      chk("t1_src",   out_src,   1'b0);
      chk("t1_data",  out_data,  exp1);
      cyc();
      chk("t1_drop", out_valid, 1'b0);
      chk("t1_busy", busy,      1'b0);

      // 2: contention with burst limit
      apply_reset();
      enable = 1'b0; out_ready = 1'b1;
      start_test(2, 8, 8);
      run(5);
      enable = 1'b1;
      nb = 0; gaps = 0; started = 0; src_seq = '0;
      for (int c = 0; c < 40 && nb < 16; c++) begin
         cyc();
         drive_next();
         if (out_valid) begin
            src_seq[15 - nb] = out_src;
            nb++; started = 1;
         end else if (started) gaps++;
      end
      chk("t2_count", nb, 16);
      chk("t2_gaps",  gaps, 0);
      chk("t2_srcseq", src_seq, 16'b0000_1111_0000_1111);

      // 3: backpressure with lane 1 streaming
      apply_reset();
      out_ready = 1'b0;
      start_test(3, 0, 5);
      run(8);
      chk("t3_hold_valid", out_valid, 1'b1);
      chk("t3_hold_data",  out_data,  beat(3, 1, 0));
      chk("t3_in1_full",   in1_ready, 1'b0);
      run(2);
      chk("t3_stable", out_data, beat(3, 1, 0));
      out_ready = 1'b1;
      nb = 0;
      for (int c = 0; c < 12 && nb < 5; c++) begin
         if (out_valid) begin
            chk("t3_order", out_data, beat(3, 1, nb));
            nb++;
         end
         cyc();
         drive_next();
      end
      chk("t3_drained", nb, 5);

      // 4: enable freeze
      apply_reset();
      out_ready = 1'b0;
      start_test(4, 3, 3);
      run(4);
      chk("t4_held", out_valid, 1'b1);
      enable = 1'b0; out_ready = 1'b1;
      lim0 = 8; lim1 = 8;
      run(1);
      chk("t4_completed", out_valid, 1'b0);
      run(6);
      chk("t4_in0_full", in0_ready, 1'b0);
      chk("t4_in1_full", in1_ready, 1'b0);
      chk("t4_frozen",   out_valid, 1'b0);
      enable = 1'b1;
      run(20);

      // 5: asynchronous reset mid-stream
      apply_reset();
      out_ready = 1'b0;
      start_test(5, 4, 3);
      run(6);
      chk("t5_pre_valid", out_valid, 1'b1);
      #2 rstn = 1'b1;
      #1;
      chk("t5_async_valid", out_valid, 1'b0);
      chk("t5_async_data",  out_data,  '0);
      chk("t5_async_busy",  busy,      1'b0);
      chk("t5_async_rdy0",  in0_ready, 1'b1);
      model_reset();
      @(negedge clk);
      rstn = 1'b0; out_ready = 1'b1;
      start_test(6, 1, 0);
      cyc(); drive_next();
      chk("t5_lat_n", out_valid, 1'b0);
      cyc(); drive_next();
      chk("t5_lat_valid", out_valid, 1'b1);
      chk("t5_new_data",  out_data,  beat(6, 0, 0));
      run(2);

      // 6: lone lane streams, then a late lane-1 beat
      apply_reset();
      out_ready = 1'b1;
      start_test(7, 6, 0);
      lone = 0; nb = 0;
      for (int c = 0; c < 10; c++) begin
         cyc(); drive_next();
         if (out_valid) begin
            nb++;
            if (out_src == 1'b0) lone++;
         end
      end
      chk("t6_lone_count", nb, 6);
      chk("t6_lone_src0",  lone, 6);
      start_test(8, 8, 0);
      run(2);
      lim1 = 1;
      seen_l1 = 0; l0_after = 0;
      for (int c = 0; c < 20 && seen_l1 == 0; c++) begin
         cyc(); drive_next();
         if (out_valid) begin
            if (out_src) seen_l1 = 1;
            else if (sent1 > 0) l0_after++;
         end
      end
      chk("t6_l1_granted", seen_l1, 1);
      chk("t6_l1_wait_le_maxb", l0_after <= MAXB, 1'b1);
      run(10);

      // random phase
      for (int c = 0; c < 400; c++) begin
         in0_valid = 1'($urandom);
         in1_valid = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         enable    = ($urandom_range(0, 7) != 0);
         for (int k = 0; k < LANES; k++) begin
            in0_data[k*DATA_W +: DATA_W] = $urandom;
            in1_data[k*DATA_W +: DATA_W] = $urandom;
         end
         cyc();
      end
      in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1; enable = 1'b1;
      repeat (15) cyc();
      chk("final_idle", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
